decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, handshaked instruction-decode stage.
- Next generation of the combinational decoder: parametrised datapath width (RV32/RV64), illegal-instruction detection, instruction-format classification, and a 2-entry skid buffer so that backpressure never drops an instruction.
- Sits between the fetch stage and the register-file/execute stage.

Parameters:
- XLEN, 32, datapath width (32 or 64); sets imm and pc widths.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry, in_ready = !out_valid | out_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept.
- instr_input  in  32  raw instruction word.
- pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  pc of the presented entry.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- imm  out  XLEN  sign-extended immediate.
- fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- illegal  out  1  instruction is not in the supported set.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, state EMPTY, and every data output 0 (fmt=7).
- Transfer rules:
  - Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
  - Latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1.
  - Outputs are driven only from registers; no combinational path from instr_input to the outputs.
  - Outputs hold stable while out_valid & !out_ready.
- State machine (SKID_EN=1), main register M and skid register S:
  - EMPTY: in_ready=1, out_valid=0. Input transfer -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input only -> TWO, new entry goes to S.
    - Output only -> EMPTY.
    - Both -> ONE, new entry goes to M.
  - TWO: in_ready=0, out_valid=1. Output transfer -> ONE, S moves to M.
- Ordering: strict program order; S is never presented ahead of M.
- SKID_EN=0: only EMPTY/ONE states. A simultaneous output and input transfer in ONE stays in ONE.
- Flush has priority over every transfer in the same cycle:
  - Next cycle: EMPTY, out_valid=0, in_ready=1.
  - An instruction offered in the flush cycle is dropped.
- Decode is combinational on the incoming word and captured at accept:
  - Opcodes map to fmt as follows: LUI/AUIPC -> U; JAL -> J; JALR/LOAD/OP-IMM/SYSTEM/MISC-MEM -> I; STORE -> S; BRANCH -> B; OP -> R.
  - When XLEN=64: OP-IMM-32 -> I, OP-32 -> R.
- Immediate (sign bit instr[31], extended to XLEN):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R/NONE -> 0.
- illegal=1 when any of the following holds; fmt is still reported:
  - instr[1:0] != 2'b11;
  - opcode is unmapped (including the RV64-only opcodes when XLEN=32);
  - R-type funct7 is not in {0000000, 0100000};
  - 0x00000000 (illegal=1, fmt=NONE).
- Boundary cases:
  - out_ready held low for many cycles: at most 2 entries held, none lost.
  - in_valid may drop without an accept; no state change.
  - Reset mid-transfer discards all entries.

Decomposition:
- decode_pkg holds:
  - opcode localparams (OP_LUI 0110111, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_IMM32, OP_REG32, OP_SYSTEM, OP_FENCE);
  - fmt encodings;
  - state encodings EMPTY/ONE/TWO.
- One combinational sub-module, decode_fields: instruction word in; fields/imm/fmt/illegal out; parametrised by XLEN.
- decode_stage instantiates decode_fields and owns the M/S registers and the FSM.

Test Plan:
- 0x00500093 (ADDI x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, fmt=I, illegal=0.
- 0x0020A023 -> fmt=S, rs1=1, rs2=2, imm=0. 0x00208463 -> fmt=B, imm=8. 0x12345037 -> fmt=U, imm=0x12345000. 0x020000EF -> fmt=J, rd=1, imm=32.
- 0xFFF00093 with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFF. Same word with XLEN=32 -> imm=0xFFFFFFFF. 0x0000001B with XLEN=32 -> illegal=1; with XLEN=64 -> illegal=0.
- out_ready=0, offer 3 back-to-back instructions (A,B,C) -> A and B accepted, in_ready=0 in the cycle after B, C stalls. Raise out_ready -> A, B, C emerge in order, one per cycle.
- State TWO, then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no entry ever emerges.
- Assert rst_n=0 asynchronously mid-stream -> out_valid drops immediately, in_ready=1. 0x00000000 and 0x02008033 (funct7=0000001) -> illegal=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings for the instruction-decode stage: RV opcodes, format codes
// and the handshake FSM states.
package decode_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [2:0] FMT_R    = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_NONE = 3'd7;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32/RV64 decoder: slices register fields, classifies the
// instruction format, builds the sign-extended immediate and flags illegal words.
module decode_fields
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]             instr,
   output logic [6:0]              opcode,
   output logic [4:0]              rd,
   output logic [4:0]              rs1,
   output logic [4:0]              rs2,
   output logic [2:0]              funct3,
   output logic [6:0]              funct7,
   output logic signed [XLEN-1:0]  imm,
   output logic [2:0]              fmt,
   output logic                    illegal
);

   logic signed [31:0] imm32;
   logic               mapped;
   logic               bad_funct7;

   always_comb begin
      opcode = instr[6:0];
      rd     = instr[11:7];
      rs1    = instr[19:15];
      rs2    = instr[24:20];
      funct3 = instr[14:12];
      funct7 = instr[31:25];

      fmt    = FMT_NONE;
      mapped = 1'b1;
      case (instr[6:0])
         OP_LUI, OP_AUIPC:                              fmt = FMT_U;
         OP_JAL:                                        fmt = FMT_J;
         OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM, OP_FENCE: fmt = FMT_I;
         OP_STORE:                                      fmt = FMT_S;
         OP_BRANCH:                                     fmt = FMT_B;
         OP_REG:                                        fmt = FMT_R;
         OP_IMM32: begin
            if (XLEN == 64) fmt = FMT_I;
            else            mapped = 1'b0;
         end
         OP_REG32: begin
            if (XLEN == 64) fmt = FMT_R;
            else            mapped = 1'b0;
         end
         default:                                       mapped = 1'b0;
      endcase

      // Immediates are assembled at 32 bits; the signed cast widens to XLEN.
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm = XLEN'(imm32);

      bad_funct7 = (fmt == FMT_R) && (instr[31:25] != F7_BASE) && (instr[31:25] != F7_ALT);
      illegal    = (instr[1:0] != 2'b11) || !mapped || bad_funct7 || (instr == 32'h0);
   end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage: decodes at accept and holds up to two
// entries (main + skid) so downstream backpressure never drops an instruction.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             instr_input,
   input  logic [XLEN-1:0]         pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_pc,
   output logic [6:0]              opcode,
   output logic [4:0]              rd,
   output logic [4:0]              rs1,
   output logic [4:0]              rs2,
   output logic [2:0]              funct3,
   output logic [6:0]              funct7,
   output logic signed [XLEN-1:0]  imm,
   output logic [2:0]              fmt,
   output logic                    illegal
);

   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic signed [XLEN-1:0] imm;
      logic [6:0]             opcode;
      logic [4:0]             rd;
      logic [4:0]             rs1;
      logic [4:0]             rs2;
      logic [2:0]             funct3;
      logic [6:0]             funct7;
      logic [2:0]             fmt;
      logic                   illegal;
   } entry_t;

   function automatic entry_t entry_rst();
      entry_t e;
      e     = '0;
      e.fmt = FMT_NONE;
      return e;
   endfunction

   entry_t entry_p0;
   entry_t m_p1;
   entry_t s_p1;
   state_t state;
   logic   vld_p1;
   logic   rdy_q;
   logic   in_xfer;
   logic   out_xfer;

   // Stage 0: combinational decode of the offered word
   decode_fields #(.XLEN(XLEN)) u_fields (
      .instr   (instr_input),
      .opcode  (entry_p0.opcode),
      .rd      (entry_p0.rd),
      .rs1     (entry_p0.rs1),
      .rs2     (entry_p0.rs2),
      .funct3  (entry_p0.funct3),
      .funct7  (entry_p0.funct7),
      .imm     (entry_p0.imm),
      .fmt     (entry_p0.fmt),
      .illegal (entry_p0.illegal)
   );
   assign entry_p0.pc = pc;

   // Without the skid entry, ready must look through to out_ready to keep full throughput.
   assign in_ready = (SKID_EN != 1'b0) ? rdy_q : (!vld_p1 || out_ready);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = vld_p1 && out_ready;

   // Stage 1: main/skid registers and handshake FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         vld_p1 <= 1'b0;
         rdy_q  <= 1'b1;
         m_p1   <= entry_rst();
         s_p1   <= entry_rst();
      end else if (flush) begin
         state  <= EMPTY;
         vld_p1 <= 1'b0;
         rdy_q  <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  m_p1   <= entry_p0;
                  state  <= ONE;
                  vld_p1 <= 1'b1;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  m_p1 <= entry_p0;
               end else if (in_xfer) begin
                  s_p1  <= entry_p0;
                  state <= TWO;
                  rdy_q <= 1'b0;
               end else if (out_xfer) begin
                  state  <= EMPTY;
                  vld_p1 <= 1'b0;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  m_p1  <= s_p1;
                  state <= ONE;
                  rdy_q <= 1'b1;
               end
            end
            default: begin
               state  <= EMPTY;
               vld_p1 <= 1'b0;
               rdy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign out_valid = vld_p1;
   assign out_pc    = m_p1.pc;
   assign opcode    = m_p1.opcode;
   assign rd        = m_p1.rd;
   assign rs1       = m_p1.rs1;
   assign rs2       = m_p1.rs2;
   assign funct3    = m_p1.funct3;
   assign funct7    = m_p1.funct7;
   assign imm       = m_p1.imm;
   assign fmt       = m_p1.fmt;
   assign illegal   = m_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32 and an RV64 instance share stimulus;
// expected values are hand-computed constants.
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr_input;
   logic [31:0] pc;
   logic [63:0] pc64;

   logic        in_ready, out_valid, illegal;
   logic [31:0] out_pc, imm;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3, fmt;

   logic        in_ready64, out_valid64, illegal64;
   logic [63:0] out_pc64, imm64;
   logic [6:0]  opcode64, funct7_64;
   logic [4:0]  rd64, rs1_64, rs2_64;
   logic [2:0]  funct3_64, fmt64;

   int n_chk;
   int n_fail;

   assign pc64 = {32'h0, pc};

   decode_stage #(.XLEN(32), .SKID_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr_input(instr_input), .pc(pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal)
   );

   decode_stage #(.XLEN(64), .SKID_EN(1'b1)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64),
      .instr_input(instr_input), .pc(pc64),
      .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
      .opcode(opcode64), .rd(rd64), .rs1(rs1_64), .rs2(rs2_64),
      .funct3(funct3_64), .funct7(funct7_64), .imm(imm64), .fmt(fmt64),
      .illegal(illegal64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word for a single cycle; the stage is assumed ready.
   task automatic send(input logic [31:0] w, input logic [31:0] p);
      in_valid    = 1'b1;
      instr_input = w;
      pc          = p;
      step();
      in_valid    = 1'b0;
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      instr_input = 32'h0;
      pc          = 32'h0;
      rst_n       = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_fmt",       64'(fmt),       64'd7);
      chk("rst_imm",       64'(imm),       64'd0);
      chk("rst_out_pc",    64'(out_pc),    64'd0);
      chk("rst_rd",        64'(rd),        64'd0);
      #9 rst_n = 1'b1;
      step();

      // Single-instruction decode, out_ready=1
      send(32'h00500093, 32'h100);
      chk("addi_valid",   64'(out_valid), 64'd1);
      chk("addi_pc",      64'(out_pc),    64'h100);
      chk("addi_rd",      64'(rd),        64'd1);
      chk("addi_rs1",     64'(rs1),       64'd0);
      chk("addi_imm",     64'(imm),       64'd5);
      chk("addi_fmt",     64'(fmt),       64'd1);
      chk("addi_illegal", 64'(illegal),   64'd0);
      step();
      chk("addi_drained", 64'(out_valid), 64'd0);

      send(32'h0020A023, 32'h104);
      chk("sw_fmt", 64'(fmt), 64'd2);
      chk("sw_rs1", 64'(rs1), 64'd1);
      chk("sw_rs2", 64'(rs2), 64'd2);
      chk("sw_imm", 64'(imm), 64'd0);
      chk("sw_f3",  64'(funct3), 64'd2);

      send(32'h00208463, 32'h108);
      chk("beq_fmt", 64'(fmt), 64'd3);
      chk("beq_imm", 64'(imm), 64'd8);

      send(32'h12345037, 32'h10C);
      chk("lui_fmt", 64'(fmt), 64'd4);
      chk("lui_imm", 64'(imm), 64'h12345000);
      chk("lui_rd",  64'(rd),  64'd0);

      send(32'h020000EF, 32'h110);
      chk("jal_fmt", 64'(fmt), 64'd5);
      chk("jal_rd",  64'(rd),  64'd1);
      chk("jal_imm", 64'(imm), 64'd32);

      send(32'hFFF00093, 32'h114);
      chk("neg_imm32", 64'(imm),   64'h00000000FFFFFFFF);
      chk("neg_imm64", imm64,      64'hFFFFFFFFFFFFFFFF);

      send(32'h0000001B, 32'h118);
      chk("addiw_ill32", 64'(illegal),   64'd1);
      chk("addiw_fmt32", 64'(fmt),       64'd7);
      chk("addiw_ill64", 64'(illegal64), 64'd0);
      chk("addiw_fmt64", 64'(fmt64),     64'd1);

      send(32'h00000000, 32'h11C);
      chk("zero_ill", 64'(illegal), 64'd1);
      chk("zero_fmt", 64'(fmt),     64'd7);

      send(32'h02008033, 32'h120);
      chk("f7bad_ill", 64'(illegal), 64'd1);
      chk("f7bad_fmt", 64'(fmt),     64'd0);

      send(32'h40208033, 32'h124);
      chk("sub_ill",    64'(illegal), 64'd0);
      chk("sub_funct7", 64'(funct7),  64'h20);

      send(32'h00500092, 32'h128);
      chk("lowbits_ill", 64'(illegal), 64'd1);
      step();

      // in_valid low for a while: no state change
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_valid", 64'(out_valid), 64'd0);
         chk("idle_ready", 64'(in_ready),  64'd1);
      end

      // Backpressure: A and B accepted, C stalls, then in-order drain
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      instr_input = 32'h00100093; pc = 32'h200;
      step();
      chk("bp_a_ready", 64'(in_ready), 64'd1);
      chk("bp_a_pc",    64'(out_pc),   64'h200);
      instr_input = 32'h00200093; pc = 32'h204;
      step();
      chk("bp_b_ready", 64'(in_ready), 64'd0);
      chk("bp_b_pc",    64'(out_pc),   64'h200);
      instr_input = 32'h00300093; pc = 32'h208;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_hold_ready", 64'(in_ready), 64'd0);
         chk("bp_hold_pc",    64'(out_pc),   64'h200);
         chk("bp_hold_imm",   64'(imm),      64'd1);
      end
      out_ready = 1'b1;
      step();
      chk("bp_out_b_pc",  64'(out_pc),    64'h204);
      chk("bp_out_b_imm", 64'(imm),       64'd2);
      chk("bp_out_b_rdy", 64'(in_ready),  64'd1);
      step();
      in_valid = 1'b0;
      chk("bp_out_c_pc",  64'(out_pc),    64'h208);
      chk("bp_out_c_vld", 64'(out_valid), 64'd1);
      step();
      chk("bp_drained",   64'(out_valid), 64'd0);

      // Flush in TWO with a simultaneous offer
      out_ready = 1'b0;
      send(32'h00100093, 32'h300);
      send(32'h00200093, 32'h304);
      chk("fl_two_ready", 64'(in_ready), 64'd0);
      flush       = 1'b1;
      in_valid    = 1'b1;
      instr_input = 32'h00400093;
      pc          = 32'h308;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ready", 64'(in_ready),  64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("fl_none", 64'(out_valid), 64'd0);
      end

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      send(32'h00100093, 32'h400);
      chk("ar_pre_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_ready", 64'(in_ready),  64'd1);
      chk("ar_pc",    64'(out_pc),    64'd0);
      #3 rst_n = 1'b1;
      step();
      chk("ar_after_valid", 64'(out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
